// File: rtl/ft2232h_rx.sv
// FT2232H sync-FIFO receive path: drains the chip over RXF#/OE#/RD# into a FWFT byte buffer.
// Define FT2232H_RX_STATS_EN to add the rx_count / burst_count statistics outputs.
module ft2232h_rx #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned HEADROOM = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rxf_n,
   input  logic [7:0]             data_in,
   output logic                   oe_n,
   output logic                   rd_n,
   output logic [7:0]             m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
`ifdef FT2232H_RX_STATS_EN
   ,
   output logic [31:0]            rx_count,
   output logic [15:0]            burst_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FullLvl  = LW'(DEPTH);
   localparam logic [LW-1:0] StartLvl = LW'(DEPTH - HEADROOM);

   if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ft2232h_rx: DEPTH must be a power of 2 and at least 8");
   end
   if (HEADROOM < 2 || HEADROOM > DEPTH) begin : g_bad_headroom
      $error("ft2232h_rx: HEADROOM must be in [2, DEPTH]");
   end

   typedef enum logic [1:0] {StIdle, StOe, StRead} state_e;

   state_e          state_q, state_d;
   logic            oe_n_q, oe_n_d;
   logic            rd_n_q, rd_n_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      mem_q [DEPTH];

   logic push, pop, accept, room;

   // Capture follows the registered strobe, not the state, so the exit-cycle byte is kept.
   assign push   = ~rd_n_q & ~rxf_n;
   assign pop    = m_valid & m_ready;
   assign accept = push & ((level_q < FullLvl) | pop);
   // Judged on post-edge occupancy so the registered RD# turn-off never outruns the buffer.
   assign room   = (level_d <= StartLvl);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!accept && pop) begin
         level_d = level_q - LW'(1);
      end
      if (push && !accept) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         oe_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         oe_n_q     <= oe_n_d;
         rd_n_q     <= rd_n_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (!rxf_n && room) state_d = StOe;
         StOe:   state_d = rxf_n ? StIdle : StRead;
         StRead: if (rxf_n || !room) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered chip strobes; OE# and RD# always release together.
   always_comb begin
      oe_n_d = 1'b1;
      rd_n_d = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!rxf_n && room) oe_n_d = 1'b0;
         end
         StOe: begin
            if (!rxf_n) begin
               oe_n_d = 1'b0;
               rd_n_d = 1'b0;
            end
         end
         StRead: begin
            if (!rxf_n && room) begin
               oe_n_d = 1'b0;
               rd_n_d = 1'b0;
            end
         end
         default: begin
            oe_n_d = 1'b1;
            rd_n_d = 1'b1;
         end
      endcase
   end

   assign oe_n     = oe_n_q;
   assign rd_n     = rd_n_q;
   assign m_valid  = (level_q != '0);
   assign m_data   = mem_q[rd_ptr_q];
   assign level    = level_q;
   assign overflow = overflow_q;

`ifdef FT2232H_RX_STATS_EN
   logic [31:0] rx_count_q, rx_count_d;
   logic [15:0] burst_count_q, burst_count_d;
   logic        burst_start;

   assign burst_start = (state_q == StOe) & ~rxf_n;

   always_comb begin
      rx_count_d    = rx_count_q + 32'(accept);
      burst_count_d = burst_count_q + 16'(burst_start);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_count_q    <= '0;
         burst_count_q <= '0;
      end else begin
         rx_count_q    <= rx_count_d;
         burst_count_q <= burst_count_d;
      end
   end

   assign rx_count    = rx_count_q;
   assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_ft2232h_rx.sv
// Directed bench for ft2232h_rx; a small chip model hands out bytes 0,1,2,... on each RD# read.
module tb_ft2232h_rx;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned HEADROOM = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxf_n;
   logic [7:0] data_in;
   logic       oe_n;
   logic       rd_n;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] level;
   logic       overflow;
`ifdef FT2232H_RX_STATS_EN
   logic [31:0] rx_count;
   logic [15:0] burst_count;
`endif

   int unsigned chip_reads = 0;
   int unsigned chip_limit = 0;
   logic        rxf_hold_n = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] got [$];
   int         pop_cyc [$];
   int         lvl_max;
   logic       s_oe, s_rd;
   int         s_lvl;
   int unsigned fill_base;

   ft2232h_rx #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rxf_n    (rxf_n),
      .data_in  (data_in),
      .oe_n     (oe_n),
      .rd_n     (rd_n),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .level    (level),
      .overflow (overflow)
`ifdef FT2232H_RX_STATS_EN
      ,
      .rx_count    (rx_count),
      .burst_count (burst_count)
`endif
   );

   always #5 clk = ~clk;

   // Chip model: RXF# low while bytes remain; each edge with RD# and RXF# low consumes one.
   assign rxf_n   = rxf_hold_n | (chip_reads >= chip_limit);
   assign data_in = chip_reads[7:0];

   always @(posedge clk) begin
      if (rd_n === 1'b0 && rxf_n === 1'b0) chip_reads <= chip_reads + 1;
   end

   // Sample at negedge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      s_oe  = oe_n;
      s_rd  = rd_n;
      s_lvl = int'(level);
      if (rst_n && m_valid && m_ready) begin
         got.push_back(m_data);
         pop_cyc.push_back(cyc);
      end
      if (s_lvl > lvl_max) lvl_max = s_lvl;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_obs();
      got.delete();
      pop_cyc.delete();
      lvl_max = 0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      rxf_hold_n = 1'b1;
      m_ready    = 1'b0;
      chip_limit = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", oe_n); end
      total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n got=%b want=1", rd_n); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
      total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      int t_oe, t_rd, gaps;
      int unsigned base;
      logic [7:0] exp_b;
      t_oe = -1; t_rd = -1; gaps = 0;
      base = chip_reads;
      clear_obs();
      rst_n      = 1'b1;
      m_ready    = 1'b1;
      chip_limit = chip_reads + 10;
      rxf_hold_n = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (t_oe < 0 && s_oe == 1'b0) t_oe = i;
         if (t_rd < 0 && s_rd == 1'b0) t_rd = i;
      end
      total++;
      if (t_oe < 0 || t_rd != t_oe + 1) begin
         bad++; $display("FAIL stream_oe_before_rd got=rd@%0d,oe@%0d want=rd one after oe", t_rd, t_oe);
      end
      total++;
      if (got.size() != 10) begin
         bad++; $display("FAIL stream_count got=%0d want=10", got.size());
      end
      for (int k = 0; k < got.size() && k < 10; k++) begin
         exp_b = 8'(base + k);
         total++;
         if (got[k] !== exp_b) begin
            bad++; $display("FAIL stream_byte%0d got=%h want=%h", k, got[k], exp_b);
         end
      end
      for (int k = 1; k < pop_cyc.size(); k++) if (pop_cyc[k] != pop_cyc[k-1] + 1) gaps++;
      total++; if (gaps != 0) begin bad++; $display("FAIL stream_rate got=%0d gaps want=0", gaps); end
      total++; if (lvl_max > 2) begin bad++; $display("FAIL stream_level_max got=%0d want<=2", lvl_max); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow got=%b want=0", overflow); end
   endtask

   task automatic test_fill();
      int rise_lvl;
      logic prev_rd;
      rise_lvl   = -1;
      prev_rd    = 1'b1;
      fill_base  = chip_reads;
      clear_obs();
      m_ready    = 1'b0;
      chip_limit = 32'hFFFF_FFFF;
      rxf_hold_n = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rise_lvl < 0 && prev_rd == 1'b0 && s_rd == 1'b1) rise_lvl = s_lvl;
         prev_rd = s_rd;
      end
      total++; if (rise_lvl != 13) begin bad++; $display("FAIL fill_rd_rise_level got=%0d want=13", rise_lvl); end
      total++; if (s_lvl != 13) begin bad++; $display("FAIL fill_final_level got=%0d want=13", s_lvl); end
      total++; if (lvl_max != 13) begin bad++; $display("FAIL fill_level_max got=%0d want=13", lvl_max); end
      total++; if (s_oe !== 1'b1 || s_rd !== 1'b1) begin
         bad++; $display("FAIL fill_bus_idle got=oe%b,rd%b want=oe1,rd1", s_oe, s_rd);
      end
      total++; if (chip_reads - fill_base != 13) begin
         bad++; $display("FAIL fill_chip_reads got=%0d want=13", chip_reads - fill_base);
      end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow got=%b want=0", overflow); end
   endtask

   task automatic test_drain();
      int restart_lvl, first_bad;
      logic [7:0] exp_b;
      restart_lvl = -1;
      first_bad   = -1;
      clear_obs();
      m_ready    = 1'b1;
      chip_limit = chip_reads + 51;
      for (int i = 0; i < 300 && got.size() < 64; i++) begin
         tick();
         if (restart_lvl < 0 && s_oe == 1'b0) restart_lvl = s_lvl;
      end
      total++; if (restart_lvl != 12) begin bad++; $display("FAIL drain_restart_level got=%0d want=12", restart_lvl); end
      total++; if (got.size() != 64) begin bad++; $display("FAIL drain_count got=%0d want=64", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         exp_b = 8'(fill_base + k);
         if (first_bad < 0 && got[k] !== exp_b) first_bad = k;
      end
      total++; if (first_bad >= 0) begin
         exp_b = 8'(fill_base + first_bad);
         bad++; $display("FAIL drain_order at %0d got=%h want=%h", first_bad, got[first_bad], exp_b);
      end
      total++; if (lvl_max > 13) begin bad++; $display("FAIL drain_level_max got=%0d want<=13", lvl_max); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL drain_overflow got=%b want=0", overflow); end
   endtask

   task automatic test_rxf_toggle();
      int entries, ent_bad, first_bad;
      int unsigned base;
      logic prev_oe, prev_rd;
      logic [7:0] exp_b;
      entries = 0; ent_bad = 0; first_bad = -1;
      prev_oe = 1'b1; prev_rd = 1'b1;
      base = chip_reads;
      clear_obs();
      m_ready    = 1'b1;
      chip_limit = 32'hFFFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         rxf_hold_n = ((i % 5) == 4);
         tick();
         if (prev_rd == 1'b1 && s_rd == 1'b0) begin
            entries++;
            if (prev_oe !== 1'b0) ent_bad++;
         end
         if (prev_oe == 1'b1 && s_oe == 1'b0 && s_rd !== 1'b1) ent_bad++;
         prev_oe = s_oe;
         prev_rd = s_rd;
      end
      rxf_hold_n = 1'b1;
      repeat (10) tick();
      total++; if (entries != 12) begin bad++; $display("FAIL toggle_entries got=%0d want=12", entries); end
      total++; if (ent_bad != 0) begin bad++; $display("FAIL toggle_sequence got=%0d bad entries want=0", ent_bad); end
      total++; if (got.size() != 24) begin bad++; $display("FAIL toggle_count got=%0d want=24", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         exp_b = 8'(base + k);
         if (first_bad < 0 && got[k] !== exp_b) first_bad = k;
      end
      total++; if (first_bad >= 0) begin
         exp_b = 8'(base + first_bad);
         bad++; $display("FAIL toggle_order at %0d got=%h want=%h", first_bad, got[first_bad], exp_b);
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      logic [7:0] exp_b;
      found = 1'b0;
      clear_obs();
      m_ready    = 1'b0;
      chip_limit = 32'hFFFF_FFFF;
      rxf_hold_n = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (level == 5'd7) begin
            found = 1'b1;
            break;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL mid_reach_level got=%0d want=7", level); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_b = chip_reads[7:0];
      @(negedge clk);
      total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL mid_oe_n got=%b want=1", oe_n); end
      total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL mid_rd_n got=%b want=1", rd_n); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got=%b want=0", m_valid); end
      total++; if (level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", level); end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10 && got.size() == 0; i++) tick();
      total++;
      if (got.size() == 0) begin
         bad++; $display("FAIL mid_first_byte got=none want=%h", exp_b);
      end else if (got[0] !== exp_b) begin
         bad++; $display("FAIL mid_first_byte got=%h want=%h", got[0], exp_b);
      end
      rxf_hold_n = 1'b1;
      repeat (20) tick();
   endtask

`ifdef FT2232H_RX_STATS_EN
   task automatic test_stats();
      int sizes [3];
      sizes = '{10, 1, 5};
      rxf_hold_n = 1'b1;
      m_ready    = 1'b1;
      rst_n      = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_obs();
      @(negedge clk);
      total++; if (rx_count !== 32'd0) begin bad++; $display("FAIL stats_rx_reset got=%0d want=0", rx_count); end
      total++; if (burst_count !== 16'd0) begin bad++; $display("FAIL stats_burst_reset got=%0d want=0", burst_count); end
      @(posedge clk);
      #1;
      for (int b = 0; b < 3; b++) begin
         chip_limit = chip_reads + sizes[b];
         rxf_hold_n = 1'b0;
         repeat (25) tick();
      end
      rxf_hold_n = 1'b1;
      total++; if (rx_count !== 32'd16) begin bad++; $display("FAIL stats_rx_count got=%0d want=16", rx_count); end
      total++; if (burst_count !== 16'd3) begin bad++; $display("FAIL stats_burst_count got=%0d want=3", burst_count); end
      total++; if (got.size() != 16) begin bad++; $display("FAIL stats_delivered got=%0d want=16", got.size()); end
   endtask
`endif

   initial begin
      lvl_max = 0;
      s_oe    = 1'b1;
      s_rd    = 1'b1;
      s_lvl   = 0;
      test_reset();
      test_stream();
      test_fill();
      test_drain();
      test_rxf_toggle();
      test_reset_mid();
`ifdef FT2232H_RX_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ft2232h_rx.md
Name: ft2232h_rx

Overview:
- Receive-side companion to the FT2232H sync-FIFO transmit stage; runs on the 60 MHz FT2232H CLKOUT domain.
- Drains the chip's receive FIFO using the RXF#/OE#/RD# protocol.
- Buffers bytes in an internal first-word-fall-through FIFO and presents them to fabric logic on a valid/ready stream.
- Throttles chip reads so downstream backpressure never loses a byte.

Parameters:
- DEPTH, 16, internal buffer depth in bytes; power of 2, >= 8.
- HEADROOM, 4, minimum free entries required to start or continue a read burst; >= 2 (covers the registered RD# turn-off latency).

Ports:
- clk  in  1  FT2232H CLKOUT, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rxf_n  in  1  chip RXF#; low = chip has data.
- data_in  in  8  chip ADBUS, sampled when read active.
- oe_n  out  1  chip OE#, registered.
- rd_n  out  1  chip RD#, registered.
- m_data  out  8  head byte of buffer.
- m_valid  out  1  buffer non-empty.
- m_ready  in  1  downstream accepts m_data this cycle.
- level  out  $clog2(DEPTH)+1  current buffer occupancy.
- overflow  out  1  sticky; a byte was received while the buffer was full.

Behaviour:
- One clock domain, one clock, synchronous active-low reset; one cycle with rst_n=0 is sufficient.
- Reset values: oe_n=1, rd_n=1, m_valid=0, level=0, overflow=0, state=IDLE, read and write pointers=0. m_data is don't-care while m_valid=0.
- free = DEPTH - level.
- State machine (all transitions on posedge clk):
  - IDLE: oe_n=1, rd_n=1. If rxf_n=0 and free >= HEADROOM: oe_n<=0, go to OE.
  - OE: oe_n held 0 for exactly one cycle (bus turnaround). If rxf_n=0: rd_n<=0, go to READ. Otherwise oe_n<=1, go to IDLE.
  - READ: hold oe_n=0, rd_n=0 while rxf_n=0 and free >= HEADROOM. If rxf_n=1 or free < HEADROOM: rd_n<=1, oe_n<=1, go to IDLE. rd_n and oe_n deassert on the same edge.
- Capture rule: push data_in into the buffer at any edge where the registered rd_n=0 and rxf_n=0. This is independent of state, so the extra byte sampled in the exit cycle is kept.
- Pop rule: pop at any edge where m_valid=1 and m_ready=1.
- First-word fall-through: m_data = mem[rd_ptr]. A byte pushed at edge N appears on m_valid/m_data after edge N (one-cycle latency).
- Push accept rule: accept if level < DEPTH, or if a pop occurs on the same edge.
  - Otherwise discard the byte and set overflow<=1. overflow clears only on reset.
  - With HEADROOM >= 2, overflow must never occur.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. level saturates at neither end (guarded by the accept rule).
- rxf_n rising mid-burst: no capture on that edge; exit to IDLE. A re-entry needs the full IDLE -> OE -> READ sequence (minimum 2 idle-bus cycles).
- Reset mid-burst: oe_n and rd_n return to 1 at the reset edge; buffer contents are discarded.
- Throughput: one byte per clk while in READ with m_ready=1.

Optional Feature:
- Macro: FT2232H_RX_STATS_EN.
- Defined:
  - Adds output rx_count [31:0]: count of bytes accepted into the buffer. Wraps at 2^32 - 1 -> 0. Reset 0.
  - Adds output burst_count [15:0]: number of OE -> READ entries. Wraps. Reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then rxf_n=0 with bytes 0x00..0x09 and m_ready=1 -> oe_n low 1 cycle before rd_n. m_data stream is 0x00..0x09 in order, one per cycle. level <= 2. overflow=0.
- rxf_n held 0 with m_ready=0, DEPTH=16, HEADROOM=4 -> rd_n rises after level reaches 12. Final level is 13 (includes the exit-cycle byte) and never exceeds 16. overflow=0.
- From the previous state, set m_ready=1 -> bytes drain in order. The read burst restarts once level <= 12. No byte is lost or duplicated across 64 bytes.
- rxf_n toggles high for 1 cycle every 5 cycles during a burst -> no capture when rxf_n=1. Each restart takes IDLE -> OE -> READ. The output sequence is contiguous.
- rst_n=0 for 1 cycle mid-burst with level=7 -> next cycle oe_n=1, rd_n=1, m_valid=0, level=0. Bytes after release start from the chip's next byte.
- FT2232H_RX_STATS_EN defined, 3 bursts of 10, 1 and 5 bytes -> rx_count=16, burst_count=3. Undefined build compiles without these ports.
